// File: rtl/koggestone_adder4_tt.sv
// ============================================================================
// Module   : koggestone_adder4_tt
// Brief    : 4-bit Kogge-Stone prefix adder TinyTapeout tile with a
//            registered debug copy of the result on the bidir outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module koggestone_adder4_tt #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_g0;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g1;
  logic [WIDTH-1:2] w_p1;
  logic [WIDTH-1:0] w_g2;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_unused;
  logic [WIDTH:0]   r_result;

  assign w_a      = ui_in[WIDTH-1:0];
  assign w_b      = ui_in[2*WIDTH-1:WIDTH];
  assign w_unused = ^uio_in;

  genvar i;

  generate
    for (i = 0; i < WIDTH; i++) begin : g_pre
      assign w_g0[i] = w_a[i] & w_b[i];
      assign w_p0[i] = w_a[i] ^ w_b[i];
    end

    // Distance-1 level; bit 1 already spans [1:0] so it only needs G.
    for (i = 0; i < WIDTH; i++) begin : g_stage1
      if (i == 0) begin : g_pass
        assign w_g1[i] = w_g0[i];
      end else if (i == 1) begin : g_gray
        assign w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
      end else begin : g_black
        assign w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
        assign w_p1[i] = w_p0[i] & w_p0[i-1];
      end
    end

    // Distance-2 level is the last one, so every cell is gray.
    for (i = 0; i < WIDTH; i++) begin : g_stage2
      if (i < 2) begin : g_pass
        assign w_g2[i] = w_g1[i];
      end else begin : g_gray
        assign w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
      end
    end

    assign w_carry[0] = 1'b0;
    for (i = 0; i < WIDTH; i++) begin : g_sum
      assign w_carry[i+1] = w_g2[i];
      assign w_sum[i]     = w_p0[i] ^ w_carry[i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else if (ena) begin
      r_result <= {w_carry[WIDTH], w_sum};
    end
  end

  assign uo_out  = {3'b000, w_carry[WIDTH], w_sum};
  assign uio_out = {3'b000, r_result};
  assign uio_oe  = 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_koggestone_adder4_tt.sv
// ============================================================================
// Module   : tb_koggestone_adder4_tt
// Brief    : Self-checking bench for koggestone_adder4_tt.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_koggestone_adder4_tt;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  koggestone_adder4_tt #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_sum(input int a, input int b);
    int s;
    s = (a + b) % 32;
    return 8'(s);
  endfunction

  initial begin
    logic [7:0] model_q;
    int ra, rb;

    checks = 0;
    errors = 0;
    vecs[0] = '{4'h0, 4'h0, 8'h00};
    vecs[1] = '{4'h3, 4'h4, 8'h07};
    vecs[2] = '{4'hF, 4'h1, 8'h10};
    vecs[3] = '{4'h1, 4'hF, 8'h10};
    vecs[4] = '{4'hF, 4'hF, 8'h1E};
    vecs[5] = '{4'h5, 4'hA, 8'h0F};

    rst    = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'hA5;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);

    // Directed table, evaluated while reset is asserted.
    for (int k = 0; k < 6; k++) begin
      ui_in = {vecs[k].b, vecs[k].a};
      #2;
      chk($sformatf("table_%0d", k), uo_out, vecs[k].exp);
    end

    // Exhaustive with rst high and ena low: no clock/reset dependency.
    for (int v = 0; v < 256; v++) begin
      ui_in  = 8'(v);
      uio_in = 8'($urandom);
      #2;
      chk($sformatf("exh_sum_%02h", v), {3'b000, uo_out[4:0]}, ref_sum(v % 16, v / 16));
      chk($sformatf("exh_top_%02h", v), {5'b0, uo_out[7:5]}, 8'h00);
      chk($sformatf("exh_oe_%02h", v), uio_oe, 8'h00);
      chk($sformatf("exh_reg_%02h", v), uio_out, 8'h00);
    end

    // Register path: capture 9+8, then hold with ena low.
    @(negedge clk);
    rst   = 1'b0;
    ena   = 1'b1;
    ui_in = {4'h8, 4'h9};
    @(posedge clk); #1;
    chk("reg_capture", uio_out, 8'h11);
    @(negedge clk);
    ena   = 1'b0;
    ui_in = {4'h3, 4'h2};
    #1;
    chk("hold_uo_tracks", uo_out, 8'h05);
    @(posedge clk); #1;
    chk("hold_1", uio_out, 8'h11);
    @(posedge clk); #1;
    chk("hold_2", uio_out, 8'h11);

    // Reset mid-operation.
    @(negedge clk);
    ena   = 1'b1;
    ui_in = {4'h4, 4'h7};
    @(posedge clk); #1;
    chk("mid_capture", uio_out, 8'h0B);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_uio", uio_out, 8'h00);
    chk("mid_rst_uo", uo_out, 8'h0B);
    chk("mid_rst_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_recover", uio_out, 8'h0B);

    // Randomised traffic against a cycle-level model of the debug register.
    model_q = 8'h0B;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      ra    = int'($urandom_range(0, 15));
      rb    = int'($urandom_range(0, 15));
      ena   = 1'($urandom);
      rst   = ($urandom_range(0, 19) == 0);
      ui_in = {4'(rb), 4'(ra)};
      #1;
      chk($sformatf("rnd_uo_%0d", n), uo_out, ref_sum(ra, rb));
      if (rst)      model_q = 8'h00;
      else if (ena) model_q = ref_sum(ra, rb);
      @(posedge clk); #1;
      chk($sformatf("rnd_uio_%0d", n), uio_out, model_q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/koggestone_adder4_tt.md
Name:
koggestone_adder4_tt

Overview:
- 4-bit unsigned adder built as a Kogge-Stone parallel-prefix carry network, packaged as a TinyTapeout user tile.
- Operands arrive on the dedicated inputs. The 4-bit sum and carry-out are driven combinationally on the dedicated outputs.
- A registered copy of the result is kept on the bidirectional output path for debug.
- No carry-in is provided.

Parameters:
- WIDTH, 4, operand width. Only 4 is supported; the prefix tree is log2(WIDTH)=2 stages.

Ports:
- clk      input   1  system clock, rising-edge.
- rst      input   1  reset: one clock; reset is synchronous and active-high.
- ena      input   1  tile enable; high when the design is selected.
- ui_in    input   8  operands: a = ui_in[3:0], b = ui_in[7:4].
- uo_out   output  8  result: uo_out[3:0] = sum, uo_out[4] = carry_out, uo_out[7:5] = 0.
- uio_in   input   8  unused; ignored.
- uio_out  output  8  registered result: {3'b000, carry_out_q, sum_q}.
- uio_oe   output  8  constant 8'h00; the bidirectional pads are never driven.

Behaviour:
- Combinational datapath (uo_out):
  - {carry_out, sum} = a + b, evaluated modulo 32, 5 bits wide.
  - Fully combinational; no clock or reset dependency; valid while rst is high; independent of ena.
- Prefix structure, which must be implemented as described and not with a behavioural "+":
  - Pre-processing, per bit i: g_i = a_i & b_i, p_i = a_i ^ b_i.
  - Stage 1, distance 1, for i=1..3: G = g_i | (p_i & g_{i-1}); P = p_i & p_{i-1}. Bit 0 passes through unchanged.
  - Stage 2, distance 2, for i=2..3: combine with bit i-2 using the same operator. Bits 0..1 pass through.
  - Carries: c_0 = 0; c_{i+1} = G[i:0], the group generate after stage 2.
  - sum_i = p_i ^ c_i; carry_out = G[3:0].
  - Black cells produce G and P; gray cells (last needed level) produce G only. Unused P terms may be omitted.
- Registered path (uio_out):
  - On each rising clk edge:
    - if rst = 1: result register <= 0.
    - else if ena = 1: result register <= {carry_out, sum}.
    - else: hold the current value.
  - Latency is one cycle from a change on ui_in to uio_out.
  - Reset value: uio_out = 8'h00.
  - rst has priority over ena. Asserting rst mid-operation clears the register on the next edge; uo_out is unaffected.
- Constant outputs:
  - uo_out[7:5] = 0 at all times.
  - uio_oe = 8'h00 at all times, including during reset.
- No X propagation: all outputs are fully defined for every ui_in value.
- Overflow wraps. Example: F+F gives sum=E, carry_out=1.

Test Plan:
- a=0, b=0 -> uo_out=8'h00. a=3, b=4 -> uo_out=8'h07.
- Carry ripple through the full prefix tree:
  - a=F, b=1 -> uo_out=8'h10 (sum=0, carry_out=1).
  - a=1, b=F -> uo_out=8'h10.
- Maximum and propagate-only cases:
  - a=F, b=F -> uo_out=8'h1E.
  - a=5, b=A -> uo_out=8'h0F, with no carry (pure propagate chain).
- Exhaustive: all 256 {b,a} combinations.
  - uo_out[4:0] must equal a+b.
  - uo_out[7:5] and uio_oe must be 0.
  - Check after a settle delay, with rst held high and ena low, to prove the combinational path has no clock or reset dependency.
- Register path:
  - Hold rst=1 for 2 cycles -> uio_out=8'h00.
  - Release rst with ena=1 and a=9, b=8 -> uio_out=8'h11 one cycle later.
  - Drop ena and change the inputs -> uio_out holds 8'h11 while uo_out tracks the new sum.
- Reset mid-operation: with ena=1 and a nonzero result registered, assert rst for 1 cycle -> uio_out=8'h00 on the next edge, while uo_out still shows a+b.
